// File: rtl/candidate_sequencer.sv
// Candidate sequencer: issues LANES consecutive candidate indices per beat from an
// aligned start up to an inclusive limit, with run/step/halt control and ready backpressure.
module candidate_sequencer #(
   parameter int WIDTH = 30,
   parameter int LANES = 8
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] start_in,
   input  logic [WIDTH-1:0] limit_in,
   input  logic             enable,
   input  logic             step,
   input  logic             ready,
   input  logic             found,
   output logic [WIDTH-1:0] base,
   output logic [LANES-1:0] lane_valid,
   output logic             valid,
   output logic             running,
   output logic             done,
   output logic             halted
);

   localparam int LB = $clog2(LANES);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      STEP,
      DONE,
      HALT
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_base;
   logic [WIDTH-1:0] r_lim;

   logic             w_presenting;
   logic [LANES-1:0] w_laneValid;
   logic             w_valid;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH:0]   w_lastLane;
   logic [WIDTH:0]   w_nextBase;

   // A beat is on the bus whenever the FSM is issuing; comparisons use one extra bit
   // so that a limit near the top of the index space cannot wrap.
   assign w_presenting = (r_state == RUN) || (r_state == STEP);

   always_comb begin
      w_laneValid = '0;
      for (int i = 0; i < LANES; i++) begin
         w_laneValid[i] = w_presenting &&
                          (({1'b0, r_base} + (WIDTH+1)'(i)) <= {1'b0, r_lim});
      end
   end

   assign w_valid    = |w_laneValid;
   assign w_accept   = w_valid && ready;
   assign w_lastLane = {1'b0, r_base} + (WIDTH+1)'(LANES - 1);
   assign w_nextBase = {1'b0, r_base} + (WIDTH+1)'(LANES);
   assign w_last     = (w_lastLane >= {1'b0, r_lim}) || w_nextBase[WIDTH];

   // Control FSM: load beats found, found beats acceptance, acceptance beats enable/step.
   // An empty first beat (limit below aligned start) retires to DONE without needing ready.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_lim   <= '1;
      end else if (load) begin
         r_state <= IDLE;
         r_base  <= {start_in[WIDTH-1:LB], {LB{1'b0}}};
         r_lim   <= limit_in;
      end else begin
         case (r_state)
            IDLE: begin
               if (found)       r_state <= HALT;
               else if (enable) r_state <= RUN;
               else if (step)   r_state <= STEP;
            end
            RUN, STEP: begin
               if (found) begin
                  r_state <= HALT;
               end else if (!w_valid) begin
                  r_state <= DONE;
               end else if (w_accept) begin
                  if (w_last) begin
                     r_state <= DONE;
                  end else begin
                     r_base  <= w_nextBase[WIDTH-1:0];
                     r_state <= ((r_state == RUN) && enable) ? RUN : IDLE;
                  end
               end
            end
            default: r_state <= r_state;
         endcase
      end
   end

   assign base       = r_base;
   assign lane_valid = w_laneValid;
   assign valid      = w_valid;
   assign running    = (r_state == RUN);
   assign done       = (r_state == DONE);
   assign halted     = (r_state == HALT);

endmodule

// File: tb/tb_candidate_sequencer.sv
// Self-checking bench for candidate_sequencer (WIDTH=8, LANES=4): directed scenarios
// plus a randomized run against a behavioural model of the issue rules.
module tb_candidate_sequencer;

   localparam int W = 8;
   localparam int L = 4;

   logic         CLK;
   logic         reset;
   logic         load;
   logic [W-1:0] start_in;
   logic [W-1:0] limit_in;
   logic         enable;
   logic         step;
   logic         ready;
   logic         found;
   logic [W-1:0] base;
   logic [L-1:0] lane_valid;
   logic         valid;
   logic         running;
   logic         done;
   logic         halted;
   logic [3:0]   status;

   int nVectors;
   int nMiscompares;

   candidate_sequencer #(.WIDTH(W), .LANES(L)) dut (
      .CLK(CLK), .reset(reset), .load(load), .start_in(start_in), .limit_in(limit_in),
      .enable(enable), .step(step), .ready(ready), .found(found), .base(base),
      .lane_valid(lane_valid), .valid(valid), .running(running), .done(done), .halted(halted)
   );

   assign status = {valid, running, done, halted};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Drive one cycle of inputs, let the edge happen, then settle away from the edge.
   task automatic applyStimulus(input logic rst, input logic ld, input logic [W-1:0] st,
                                input logic [W-1:0] lm, input logic en, input logic sp,
                                input logic rd, input logic fd);
      reset = rst; load = ld; start_in = st; limit_in = lm;
      enable = en; step = sp; ready = rd; found = fd;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [W-1:0] gotBase, input logic [W-1:0] wantBase,
                      input logic [3:0] gotLv, input logic [3:0] wantLv,
                      input logic [3:0] gotSt, input logic [3:0] wantSt);
      nVectors++;
      if (gotBase !== wantBase || gotLv !== wantLv || gotSt !== wantSt) begin
         nMiscompares++;
         $display("[TB] FAIL %s: base=%h lane_valid=%h status=%b, expected base=%h lane_valid=%h status=%b",
                  name, gotBase, gotLv, gotSt, wantBase, wantLv, wantSt);
      end
   endtask

   task automatic test_reset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      if (base !== 8'h00 || lane_valid !== 4'h0 || status !== 4'b0000) begin
         nMiscompares++;
         $display("[TB] FAIL reset: base=%h lane_valid=%h status=%b, expected 00 0 0000", base, lane_valid, status);
      end
      nVectors++;
   endtask

   task automatic test_full_run();
      logic [W-1:0] expBase [4];
      expBase = '{8'h10, 8'h14, 8'h18, 8'h1C};
      applyStimulus(0, 1, 8'h10, 8'h1F, 0, 0, 0, 0);
      chk("full_load", base, 8'h10, lane_valid, 4'h0, status, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
         chk($sformatf("full_beat%0d", k), base, expBase[k], lane_valid, 4'hF, status, 4'b1100);
      end
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
      chk("full_done", base, 8'h1C, lane_valid, 4'h0, status, 4'b0010);
   endtask

   task automatic test_partial();
      applyStimulus(0, 1, 8'h12, 8'h16, 0, 0, 0, 0);
      chk("part_load", base, 8'h10, lane_valid, 4'h0, status, 4'b0000);
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
      chk("part_beat0", base, 8'h10, lane_valid, 4'hF, status, 4'b1100);
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
      chk("part_beat1", base, 8'h14, lane_valid, 4'h7, status, 4'b1100);
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
      chk("part_done", base, 8'h14, lane_valid, 4'h0, status, 4'b0010);
   endtask

   task automatic test_stall();
      applyStimulus(0, 1, 8'h20, 8'hFF, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      chk("stall_present", base, 8'h20, lane_valid, 4'hF, status, 4'b1100);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
         chk($sformatf("stall_hold%0d", k), base, 8'h20, lane_valid, 4'hF, status, 4'b1100);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      chk("stall_release", base, 8'h24, lane_valid, 4'h0, status, 4'b0000);
   endtask

   task automatic test_step();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      chk("step_first", base, 8'h00, lane_valid, 4'hF, status, 4'b1000);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      chk("step_ignored", base, 8'h00, lane_valid, 4'hF, status, 4'b1000);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      chk("step_accept0", base, 8'h04, lane_valid, 4'h0, status, 4'b0000);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
      chk("step_second", base, 8'h04, lane_valid, 4'hF, status, 4'b1000);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      chk("step_accept1", base, 8'h08, lane_valid, 4'h0, status, 4'b0000);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      chk("step_quiet", base, 8'h08, lane_valid, 4'h0, status, 4'b0000);
   endtask

   task automatic test_found();
      applyStimulus(0, 1, 8'h00, 8'hFF, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
      chk("found_pre", base, 8'h08, lane_valid, 4'hF, status, 4'b1100);
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 1);
      chk("found_halt", base, 8'h08, lane_valid, 4'h0, status, 4'b0001);
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
      chk("found_enable_ignored", base, 8'h08, lane_valid, 4'h0, status, 4'b0001);
      applyStimulus(0, 1, 8'h40, 8'hFF, 0, 0, 0, 0);
      chk("found_cleared", base, 8'h40, lane_valid, 4'h0, status, 4'b0000);
   endtask

   task automatic test_empty();
      applyStimulus(0, 1, 8'h23, 8'h10, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      chk("empty_beat", base, 8'h20, lane_valid, 4'h0, status, 4'b0100);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      chk("empty_done", base, 8'h20, lane_valid, 4'h0, status, 4'b0010);
   endtask

   task automatic test_reset_mid_beat();
      applyStimulus(0, 1, 8'h30, 8'hFF, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 1, 0);
      chk("rstmid_clear", base, 8'h00, lane_valid, 4'h0, status, 4'b0000);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      chk("rstmid_noaccept", base, 8'h00, lane_valid, 4'h0, status, 4'b0000);
   endtask

   task automatic test_wrap();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 64; k++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
         if (k % 16 == 0 || k == 63)
            chk($sformatf("wrap_beat%0d", k), base, W'(k * 4), lane_valid, 4'hF, status, 4'b1100);
      end
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
      chk("wrap_done", base, 8'hFC, lane_valid, 4'h0, status, 4'b0010);
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 1);
      chk("wrap_done_hold", base, 8'hFC, lane_valid, 4'h0, status, 4'b0010);
   endtask

   // Behavioural model: state as one of the five named modes, numbers as plain ints.
   localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DONE = 3, M_HALT = 4;

   function automatic logic [3:0] modelMask(int b, int lim, int mode);
      int n;
      if (mode != M_RUN && mode != M_STEP) return 4'h0;
      n = lim - b + 1;
      if (n < 0) n = 0;
      if (n > L) n = L;
      return 4'((1 << n) - 1);
   endfunction

   function automatic logic [3:0] modelStatus(logic [3:0] mask, int mode);
      return {mask != 4'h0, mode == M_RUN, mode == M_DONE, mode == M_HALT};
   endfunction

   task automatic test_random();
      int mBase, mLim, mMode, gap;
      logic rst, ld, en, sp, rd, fd;
      logic [W-1:0] st, lm;
      logic [3:0] mask;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      mBase = 0; mLim = 255; mMode = M_IDLE;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 99) < 2);
         ld  = ($urandom_range(0, 99) < 6);
         fd  = ($urandom_range(0, 99) < 3);
         en  = ($urandom_range(0, 99) < 60);
         sp  = ($urandom_range(0, 99) < 25);
         rd  = ($urandom_range(0, 99) < 70);
         st  = W'($urandom_range(0, 255));
         gap = $urandom_range(0, 40) - 4;
         lm  = (int'(st) + gap > 255) ? 8'hFF : (int'(st) + gap < 0) ? 8'h00 : W'(int'(st) + gap);
         mask = modelMask(mBase, mLim, mMode);
         if (rst) begin
            mBase = 0; mLim = 255; mMode = M_IDLE;
         end else if (ld) begin
            mBase = int'(st) / L * L; mLim = int'(lm); mMode = M_IDLE;
         end else if (fd && (mMode == M_IDLE || mMode == M_RUN || mMode == M_STEP)) begin
            mMode = M_HALT;
         end else if (mMode == M_RUN || mMode == M_STEP) begin
            if (mask == 4'h0) mMode = M_DONE;
            else if (rd) begin
               if (mBase + L - 1 >= mLim) mMode = M_DONE;
               else begin
                  mBase = mBase + L;
                  mMode = (mMode == M_RUN && en) ? M_RUN : M_IDLE;
               end
            end
         end else if (mMode == M_IDLE) begin
            if (en) mMode = M_RUN;
            else if (sp) mMode = M_STEP;
         end
         applyStimulus(rst, ld, st, lm, en, sp, rd, fd);
         mask = modelMask(mBase, mLim, mMode);
         chk($sformatf("rand_c%0d", c), base, W'(mBase), lane_valid, mask, status, modelStatus(mask, mMode));
      end
   endtask

   initial begin
      nVectors = 0;
      nMiscompares = 0;
      reset = 1; load = 0; start_in = 0; limit_in = 0;
      enable = 0; step = 0; ready = 0; found = 0;
      test_reset();
      test_full_run();
      test_partial();
      test_stall();
      test_step();
      test_found();
      test_empty();
      test_reset_mid_beat();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/candidate_sequencer.md
CANDIDATE_SEQUENCER -- requirements
Module: candidate_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 30, giving the candidate index width in bits.
REQ-002 The block SHALL have parameter LANES, default 8, giving the candidates issued per beat; it is a power of two, at least 2 and at most 2^(WIDTH-1); LB = log2(LANES).
REQ-003 Reset SHALL be reset, synchronous, active-high; the clock SHALL be CLK.
REQ-004 Port CLK: input, 1 bit, clock, all state changes on its rising edge.
REQ-005 Port reset: input, 1 bit, synchronous active-high reset.
REQ-006 Port load: input, 1 bit, captures start_in and limit_in.
REQ-007 Port start_in: input, WIDTH bits, first candidate; its low LB bits SHALL be ignored and treated as zero.
REQ-008 Port limit_in: input, WIDTH bits, last candidate, inclusive.
REQ-009 Port enable: input, 1 bit, level request for free-running issue.
REQ-010 Port step: input, 1 bit, single-cycle pulse requesting exactly one beat.
REQ-011 Port ready: input, 1 bit, downstream accepts the current beat.
REQ-012 Port found: input, 1 bit, pulse from the hash comparators requesting a halt.
REQ-013 Port base: output, WIDTH bits, lane-0 candidate of the current beat.
REQ-014 Port lane_valid: output, LANES bits; bit i marks candidate base+i as valid.
REQ-015 Port valid: output, 1 bit, equal to the OR of lane_valid.
REQ-016 Port running, done and halted: outputs, 1 bit each, status flags.

Function
REQ-017 States SHALL be IDLE, RUN, STEP, DONE and HALT; running SHALL be 1 only in RUN, done only in DONE, halted only in HALT.
REQ-018 The internal limit register (lim) and base SHALL be loaded on load; load SHALL force IDLE, clear done and halted, and drop valid on the next cycle, in any state.
REQ-019 Event priority SHALL be: reset > load > found > beat acceptance > enable > step.
REQ-020 A beat is accepted when valid=1 and ready=1 in the same cycle.
REQ-021 While valid=1 and ready=0, base and lane_valid SHALL hold stable; deasserting enable SHALL NOT withdraw a presented beat.
REQ-022 lane_valid[i] SHALL be 1 iff the state is RUN or STEP, a beat is presented, and base+i <= lim, compared in WIDTH+1 bits.
REQ-023 From IDLE: enable=1 SHALL go to RUN and present the beat on the next cycle; otherwise step=1 SHALL go to STEP; with neither, the state SHALL stay IDLE.
REQ-024 In RUN, on acceptance: base SHALL advance by LANES; the next beat SHALL be presented on the following cycle if enable=1 (one beat per cycle at full throughput), else the state SHALL return to IDLE (paused).
REQ-025 In STEP, on acceptance: base SHALL advance by LANES and the state SHALL return to IDLE; a step pulse while not in IDLE SHALL be ignored.
REQ-026 On acceptance of a beat where base+LANES-1 >= lim, or where base+LANES overflows 2^WIDTH, the state SHALL go to DONE and base SHALL hold its last value.
REQ-027 When lim < aligned start, the first beat SHALL present lane_valid=0; in that case the state SHALL enter DONE immediately from RUN or STEP without waiting for ready.
REQ-028 In DONE, enable and step SHALL be ignored; only load or reset SHALL exit DONE.
REQ-029 found=1 in RUN, STEP or IDLE SHALL enter HALT on the next edge and drop valid; base SHALL retain the last accepted or presented beat for readback.
REQ-030 found=1 SHALL be ignored in DONE and in HALT.
REQ-031 In HALT, only load or reset SHALL exit.

Reset
REQ-032 On reset, base SHALL be 0, lim SHALL be all ones, the state SHALL be IDLE, and lane_valid, valid, running, done and halted SHALL all be 0, on the cycle following the reset edge.
REQ-033 Reset asserted mid-beat SHALL discard the pending beat with no acceptance.

Verification (WIDTH=8, LANES=4)
REQ-034 The bench SHALL cover: reset; load start=0x10, limit=0x1F; enable=1, ready=1 -> bases 0x10,0x14,0x18,0x1C on consecutive cycles, all lane_valid=4'hF, then done=1, running=0.
REQ-035 The bench SHALL cover: load start=0x12, limit=0x16 -> base=0x10 with lane_valid=4'hF, then base=0x14 with lane_valid=4'h7, then DONE.
REQ-036 The bench SHALL cover: RUN with ready=0 for 3 cycles and enable dropped during the stall -> base stays stable, the beat is accepted when ready rises, then IDLE with base+4.
REQ-037 The bench SHALL cover: step pulses x2 from IDLE -> exactly two beats 0x00 and 0x04, then IDLE; a step issued during STEP has no effect.
REQ-038 The bench SHALL cover: found asserted while base=0x08 in RUN -> halted=1 and valid=0 on the next cycle, base=0x08; a following enable has no effect; load clears halted.
REQ-039 The bench SHALL cover: default limit 0xFF -> the final beat at 0xFC has lane_valid=4'hF, base+4 wraps, and DONE holds with base=0xFC.
